// File: rtl/mipi_csi_rx_pkg.sv
// Shared definitions for the MIPI CSI RX path: deskew FSM states and the
// skew counter width helper used by the deskew stage and its lane delays.
package mipi_csi_rx_pkg;

   typedef enum logic [2:0] {
      DS_IDLE      = 3'd0,
      DS_ARM       = 3'd1,
      DS_ALIGNED   = 3'd2,
      DS_WAIT_IDLE = 3'd3,
      DS_ERROR     = 3'd4
   } deskew_state_e;

   // Width of a counter that must hold 0..max_skew inclusive.
   function automatic int skew_cnt_w(input int max_skew);
      return (max_skew < 1) ? 1 : $clog2(max_skew + 1);
   endfunction

endpackage

// File: rtl/mipi_csi_rx_lane_deskew_if.sv
// Lane bus between the byte aligners, the deskew stage and the packet decoder.
// master = upstream/downstream environment, slave = deskew stage.
interface mipi_csi_rx_lane_deskew_if #(
   parameter int MIPI_GEAR  = 16,
   parameter int MIPI_LANES = 4
);

   logic [MIPI_LANES-1:0]           bytes_valid_i;
   logic [MIPI_GEAR*MIPI_LANES-1:0] byte_i;
   logic [MIPI_GEAR*MIPI_LANES-1:0] lane_byte_o;
   logic                            lane_valid_o;
   logic                            skew_error_o;

   modport master (
      output bytes_valid_i,
      output byte_i,
      input  lane_byte_o,
      input  lane_valid_o,
      input  skew_error_o
   );

   modport slave (
      input  bytes_valid_i,
      input  byte_i,
      output lane_byte_o,
      output lane_valid_o,
      output skew_error_o
   );

endinterface

// File: rtl/mipi_csi_rx_lane_delay.sv
// One lane's delay line: a free-running history of past bytes plus a tap
// mux selecting the byte delayed by tap_i clocks (0 = current byte).
module mipi_csi_rx_lane_delay
   import mipi_csi_rx_pkg::*;
#(
   parameter int MIPI_GEAR = 16,
   parameter int MAX_SKEW  = 7
) (
   input  logic                              clk_i,
   input  logic [MIPI_GEAR-1:0]              byte_i,
   input  logic [skew_cnt_w(MAX_SKEW)-1:0]   tap_i,
   output logic [MIPI_GEAR-1:0]              byte_o
);

   // hist_reg[i] holds byte_i delayed by i+1 clocks; contents need no reset.
   logic [MIPI_GEAR-1:0] hist_reg [MAX_SKEW];

   // First history stage captures the live byte every clock.
   always_ff @(posedge clk_i) begin
      hist_reg[0] <= byte_i;
   end

   genvar gi;
   generate
      for (gi = 1; gi < MAX_SKEW; gi++) begin : g_hist
         // Remaining stages shift unconditionally, independent of FSM state.
         always_ff @(posedge clk_i) begin
            hist_reg[gi] <= hist_reg[gi-1];
         end
      end
   endgenerate

   // Tap select; out-of-range taps fall back to the live byte.
   always_comb begin
      byte_o = byte_i;
      for (int i = 0; i < MAX_SKEW; i++) begin
         if (int'(tap_i) == i + 1) begin
            byte_o = hist_reg[i];
         end
      end
   end

endmodule

// File: rtl/mipi_csi_rx_lane_deskew.sv
// Multi-lane deskew: measures inter-lane start skew at each HS burst, delays
// early lanes so every lane's sync byte lines up, and emits one coherent word
// with a single valid. Skew beyond MAX_SKEW flags skew_error_o for the burst.
module mipi_csi_rx_lane_deskew
   import mipi_csi_rx_pkg::*;
#(
   parameter int MIPI_GEAR  = 16,
   parameter int MIPI_LANES = 4,
   parameter int MAX_SKEW   = 7
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   mipi_csi_rx_lane_deskew_if.slave     bus
);

   localparam int SKEW_CNT_W = skew_cnt_w(MAX_SKEW);
   localparam int WORD_W     = MIPI_GEAR * MIPI_LANES;
   localparam logic [SKEW_CNT_W-1:0] CNT_LIMIT = SKEW_CNT_W'(MAX_SKEW);

   deskew_state_e state_reg, state_next;

   logic [MIPI_LANES-1:0][SKEW_CNT_W-1:0] cnt_reg, cnt_next;
   logic [MIPI_LANES-1:0][SKEW_CNT_W-1:0] tap_reg, tap_next;
   logic [MIPI_LANES-1:0][SKEW_CNT_W-1:0] tap_sel;

   logic [WORD_W-1:0] lane_byte_reg, lane_byte_next;
   logic              lane_valid_reg, lane_valid_next;
   logic              skew_error_reg, skew_error_next;

   logic [WORD_W-1:0]     delayed_word;
   logic [MIPI_LANES-1:0] lane_seen;
   logic [MIPI_LANES-1:0] lane_at_limit;
   logic                  all_high;
   logic                  any_high;
   logic                  lane_dropped;
   logic                  limit_hit;

   // Per-lane delay lines; tap_sel is the tap in force for the word being
   // registered this clock (measured counts on the alignment clock itself).
   genvar gi;
   generate
      for (gi = 0; gi < MIPI_LANES; gi++) begin : g_lane
         mipi_csi_rx_lane_delay #(
            .MIPI_GEAR (MIPI_GEAR),
            .MAX_SKEW  (MAX_SKEW)
         ) u_delay (
            .clk_i  (clk_i),
            .byte_i (bus.byte_i[gi*MIPI_GEAR +: MIPI_GEAR]),
            .tap_i  (tap_sel[gi]),
            .byte_o (delayed_word[gi*MIPI_GEAR +: MIPI_GEAR])
         );
      end
   endgenerate

   // Lane status summaries: which lanes have already started this burst,
   // and which active lanes would step past the skew limit this clock.
   always_comb begin
      lane_seen     = '0;
      lane_at_limit = '0;
      for (int k = 0; k < MIPI_LANES; k++) begin
         lane_seen[k]     = (cnt_reg[k] != '0);
         lane_at_limit[k] = bus.bytes_valid_i[k] && (cnt_reg[k] == CNT_LIMIT);
      end
   end

   assign all_high     = &bus.bytes_valid_i;
   assign any_high     = |bus.bytes_valid_i;
   assign lane_dropped = |(lane_seen & ~bus.bytes_valid_i);
   assign limit_hit    = |lane_at_limit;

   // Next-state, counter, tap and output decisions.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = '0;
      tap_next        = tap_reg;
      tap_sel         = cnt_reg;
      lane_byte_next  = lane_byte_reg;
      lane_valid_next = 1'b0;
      skew_error_next = 1'b0;

      case (state_reg)
         DS_IDLE: begin
            if (all_high) begin
               // Counters are zero here, so the live bytes go straight out.
               state_next      = DS_ALIGNED;
               tap_next        = '0;
               lane_byte_next  = delayed_word;
               lane_valid_next = 1'b1;
            end else if (any_high) begin
               state_next = DS_ARM;
               for (int k = 0; k < MIPI_LANES; k++) begin
                  cnt_next[k] = SKEW_CNT_W'(bus.bytes_valid_i[k]);
               end
            end
         end

         DS_ARM: begin
            if (all_high) begin
               // Last lane arrived: freeze the measured skews as taps and
               // emit the sync word on this same clock.
               state_next      = DS_ALIGNED;
               tap_next        = cnt_reg;
               lane_byte_next  = delayed_word;
               lane_valid_next = 1'b1;
            end else if (lane_dropped) begin
               // An aligner was reset by LP; abandon the burst quietly.
               state_next = DS_IDLE;
            end else if (limit_hit) begin
               state_next      = DS_ERROR;
               skew_error_next = 1'b1;
            end else begin
               for (int k = 0; k < MIPI_LANES; k++) begin
                  cnt_next[k] = cnt_reg[k] + SKEW_CNT_W'(bus.bytes_valid_i[k]);
               end
            end
         end

         DS_ALIGNED: begin
            tap_sel = tap_reg;
            if (all_high) begin
               lane_byte_next  = delayed_word;
               lane_valid_next = 1'b1;
            end else begin
               state_next = DS_WAIT_IDLE;
            end
         end

         DS_WAIT_IDLE: begin
            if (!any_high) begin
               state_next = DS_IDLE;
            end
         end

         DS_ERROR: begin
            if (!any_high) begin
               state_next = DS_IDLE;
            end else begin
               skew_error_next = 1'b1;
            end
         end

         default: begin
            state_next = DS_IDLE;
         end
      endcase
   end

   // State, measurement and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg      <= DS_IDLE;
         cnt_reg        <= '0;
         tap_reg        <= '0;
         lane_byte_reg  <= '0;
         lane_valid_reg <= 1'b0;
         skew_error_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         tap_reg        <= tap_next;
         lane_byte_reg  <= lane_byte_next;
         lane_valid_reg <= lane_valid_next;
         skew_error_reg <= skew_error_next;
      end
   end

   assign bus.lane_byte_o  = lane_byte_reg;
   assign bus.lane_valid_o = lane_valid_reg;
   assign bus.skew_error_o = skew_error_reg;

endmodule

// File: tb/tb_mipi_csi_rx_lane_deskew.sv
// Directed bench for the lane deskew stage: each burst gives per-lane start
// and stop clocks; every lane carries sync 0x00B8 then 0x1001, 0x1002, ...
// so a correctly deskewed output word holds the same value in all lanes.
module tb_mipi_csi_rx_lane_deskew;

   localparam int G = 16;
   localparam int L = 4;
   localparam int NEVER = 1000;

   logic clk_i;
   logic reset_i;

   int err_cnt = 0;
   int chk_cnt = 0;

   int s_at [L];
   int e_at [L];

   mipi_csi_rx_lane_deskew_if #(.MIPI_GEAR(G), .MIPI_LANES(L)) bus ();

   mipi_csi_rx_lane_deskew #(
      .MIPI_GEAR  (G),
      .MIPI_LANES (L),
      .MAX_SKEW   (7)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [G-1:0] lane_word(input int n);
      return (n == 0) ? 16'h00B8 : 16'h1000 + 16'(n);
   endfunction

   function automatic logic [G*L-1:0] coherent(input int n);
      logic [G*L-1:0] w;
      for (int k = 0; k < L; k++) w[k*G +: G] = lane_word(n);
      return w;
   endfunction

   // Drive one clock of lane inputs for burst-relative cycle c.
   task automatic drive_cycle(input int c);
      for (int k = 0; k < L; k++) begin
         if (c >= s_at[k] && c < e_at[k]) begin
            bus.bytes_valid_i[k]  = 1'b1;
            bus.byte_i[k*G +: G]  = lane_word(c - s_at[k]);
         end else begin
            bus.bytes_valid_i[k]  = 1'b0;
            bus.byte_i[k*G +: G]  = 16'hE000 | 16'(k << 8) | 16'(c & 255);
         end
      end
   endtask

   // Run one burst and check every output clock against the expected shape.
   task automatic run_burst(input string name,
                            input int s0, input int s1, input int s2, input int s3,
                            input int e0, input int e1, input int e2, input int e3,
                            input int ncyc, input bit exp_align,
                            input int err_from, input int err_to, input int rst_at);
      int last_start;
      int first_stop;
      bit exp_valid;
      bit exp_err;
      s_at[0] = s0; s_at[1] = s1; s_at[2] = s2; s_at[3] = s3;
      e_at[0] = e0; e_at[1] = e1; e_at[2] = e2; e_at[3] = e3;
      last_start = s0;
      first_stop = e0;
      for (int k = 1; k < L; k++) begin
         if (s_at[k] > last_start) last_start = s_at[k];
         if (e_at[k] < first_stop) first_stop = e_at[k];
      end
      for (int c = 0; c < ncyc; c++) begin
         drive_cycle(c);
         reset_i = (c == rst_at);
         @(posedge clk_i);
         #1;
         exp_err = (c >= err_from) && (c < err_to);
         if (rst_at >= 0 && c >= rst_at) begin
            check_val($sformatf("%s.valid@%0d", name, c), {63'b0, bus.lane_valid_o}, 64'd0);
            check_val($sformatf("%s.err@%0d", name, c), {63'b0, bus.skew_error_o}, 64'd0);
            check_val($sformatf("%s.rstword@%0d", name, c), bus.lane_byte_o, 64'd0);
         end else begin
            exp_valid = exp_align && (c >= last_start) && (c < first_stop);
            check_val($sformatf("%s.valid@%0d", name, c), {63'b0, bus.lane_valid_o}, {63'b0, exp_valid});
            check_val($sformatf("%s.err@%0d", name, c), {63'b0, bus.skew_error_o}, {63'b0, exp_err});
            if (exp_valid)
               check_val($sformatf("%s.word@%0d", name, c), bus.lane_byte_o, coherent(c - last_start));
            else if (exp_align && c >= first_stop)
               check_val($sformatf("%s.hold@%0d", name, c), bus.lane_byte_o,
                         coherent(first_stop - 1 - last_start));
         end
      end
      reset_i = 1'b0;
      $display("burst %s done: checks=%0d errors=%0d", name, chk_cnt, err_cnt);
   endtask

   initial begin
      reset_i = 1'b1;
      bus.bytes_valid_i = '0;
      bus.byte_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check_val("reset.valid", {63'b0, bus.lane_valid_o}, 64'd0);
      check_val("reset.err", {63'b0, bus.skew_error_o}, 64'd0);
      check_val("reset.word", bus.lane_byte_o, 64'd0);
      reset_i = 1'b0;

      // All lanes start together: taps 0, sync word next clock.
      run_burst("sync", 2, 2, 2, 2, 10, 10, 10, 10, 14, 1'b1, -1, -1, -1);
      // Skewed start, taps 3,2,0,1.
      run_burst("skew", 2, 3, 5, 4, 14, 14, 14, 14, 18, 1'b1, -1, -1, -1);
      // Lane 2 early by exactly MAX_SKEW: accepted.
      run_burst("max7", 9, 9, 2, 9, 20, 20, 20, 20, 24, 1'b1, -1, -1, -1);
      // Lane 2 early by MAX_SKEW+1: error from clock 9 until all lanes low at 18.
      run_burst("over8", 10, 10, 2, 10, 18, 18, 18, 18, 22, 1'b0, 9, 18, -1);
      // Lane 1 alone arms, then drops: back to idle with no error.
      run_burst("armdrop", NEVER, 2, NEVER, NEVER, NEVER, 5, NEVER, NEVER, 10, 1'b0, -1, -1, -1);
      run_burst("after", 3, 3, 3, 3, 9, 9, 9, 9, 12, 1'b1, -1, -1, -1);
      // Lane 3 drops mid-burst; later lanes' trailing bytes discarded.
      run_burst("l3drop", 2, 4, 3, 2, 20, 20, 20, 12, 24, 1'b1, -1, -1, -1);
      // Fresh skew measured on the next burst.
      run_burst("remeas", 4, 2, 3, 2, 12, 12, 12, 12, 16, 1'b1, -1, -1, -1);
      // Reset while aligned: zero outputs next clock.
      run_burst("rst", 2, 3, 2, 2, 9, 9, 9, 9, 12, 1'b1, -1, -1, 8);
      run_burst("recover", 5, 2, 3, 4, 13, 13, 13, 13, 16, 1'b1, -1, -1, -1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
